// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory port.
//
// Handshake: a requester raises *_req together with its address (and, on the
// data side, write enable and store data) and holds all of them unchanged
// until the matching *_data_valid pulse. That pulse lasts exactly one cycle
// and the read data beside it is meaningful only in that cycle (0 otherwise).
// Toward memory, m_req stays high with stable m_address/m_we/m_wdata for the
// whole access; the memory finishes it with a single-cycle m_ack, presenting
// m_rdata in that same cycle. m_ack while m_req is low is ignored.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_address;
    logic [31:0] i_data_read;
    logic        i_data_valid;
    logic        d_req;
    logic        d_write_enable;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic [31:0] d_data_read;
    logic        d_data_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_error;

    // Arbiter side
    modport master (
        input  i_req, i_address, d_req, d_write_enable, d_address, d_data_write,
        input  m_rdata, m_ack,
        output i_data_read, i_data_valid, d_data_read, d_data_valid,
        output m_req, m_we, m_address, m_wdata, bus_error
    );

    // Requester / memory side
    modport slave (
        output i_req, i_address, d_req, d_write_enable, d_address, d_data_write,
        output m_rdata, m_ack,
        input  i_data_read, i_data_valid, d_data_read, d_data_valid,
        input  m_req, m_we, m_address, m_wdata, bus_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs data load/store. The data
// side is preferred, but a waiting fetch is granted after STARVE_MAX data
// grants in a row. An access that sees no m_ack for TIMEOUT cycles is aborted
// with a bus_error pulse and a zero-data valid to the requester.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_e;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    // wait_cnt holds the ack-less cycles already spent, so the TIMEOUT-th
    // access cycle is the one entered with wait_cnt == TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  starve_cnt;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        grant_d, grant_i;
    logic        in_acc, timeout, done;

    assign in_acc    = (state_q != IDLE);
    assign timeout   = in_acc && !bus.m_ack && (wait_cnt == WAIT_LAST);
    assign done      = in_acc && (bus.m_ack || timeout);
    assign dbg_state = state_q;

    // Arbitration: data wins unless a fetch has been passed over too often
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            if (bus.d_req && (!bus.i_req || (starve_cnt < STARVE_LIM))) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one access at a time, always passing back through IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_ACC;
                end else if (grant_i) begin
                    state_d = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory side from latched request, completion side combinational
    always_comb begin
        bus.m_req        = in_acc;
        bus.m_we         = we_q;
        bus.m_address    = addr_q;
        bus.m_wdata      = wdata_q;
        bus.bus_error    = timeout;
        bus.i_data_valid = (state_q == I_ACC) && done;
        bus.d_data_valid = (state_q == D_ACC) && done;
        bus.i_data_read  = 32'h0;
        bus.d_data_read  = 32'h0;
        if ((state_q == I_ACC) && bus.m_ack) begin
            bus.i_data_read = bus.m_rdata;
        end
        if ((state_q == D_ACC) && bus.m_ack && !we_q) begin
            bus.d_data_read = bus.m_rdata;
        end
    end

    // Latch the winning request on the grant edge; held for the whole access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= bus.d_address;
            wdata_q <= bus.d_data_write;
            we_q    <= bus.d_write_enable;
        end else if (grant_i) begin
            addr_q  <= bus.i_address;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
        end
    end

    // Starvation counter: data grants made while a fetch is waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 3'd0;
        end else if (grant_i) begin
            starve_cnt <= 3'd0;
        end else if (grant_d) begin
            if (!bus.i_req) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Wait counter: ack-less cycles of the current access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (grant_d || grant_i) begin
            wait_cnt <= 8'd0;
        end else if (in_acc && !bus.m_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- STARVE_MAX, 4: max consecutive data grants while a fetch waits.
- TIMEOUT, 255: max cycles an access waits for m_ack before abort.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- i_req, in, 1: fetch request, held until i_data_valid.
- i_address, in, 32: fetch address.
- i_data_read, out, 32: fetch data.
- i_data_valid, out, 1: fetch complete pulse.
- d_req, in, 1: data request, held until d_data_valid.
- d_write_enable, in, 1: 1 = store, 0 = load.
- d_address, in, 32: data address.
- d_data_write, in, 32: store data.
- d_data_read, out, 32: load data.
- d_data_valid, out, 1: data access complete pulse.
- m_req, out, 1: memory request.
- m_we, out, 1: memory write strobe.
- m_address, out, 32: memory address.
- m_wdata, out, 32: memory write data.
- m_rdata, in, 32: memory read data, valid with m_ack.
- m_ack, in, 1: memory completion pulse.
- bus_error, out, 1: timeout pulse.

Function
REQ-003 The block SHALL implement FSM states IDLE, I_ACC, D_ACC, one-hot or encoded.
REQ-004 In IDLE with d_req=1 and either i_req=0 or starve_cnt<STARVE_MAX, the block SHALL go to D_ACC.
REQ-005 In IDLE with i_req=1 and either d_req=0 or starve_cnt>=STARVE_MAX, the block SHALL go to I_ACC.
REQ-006 The block SHALL hold in IDLE when both requests are 0.
REQ-007 On the grant edge the block SHALL latch the address, plus d_write_enable and d_data_write for D_ACC.
- Requester inputs SHALL be ignored during the access.
REQ-008 In I_ACC and D_ACC the block SHALL drive m_req=1 and stable latched m_address, m_we and m_wdata.
- m_we SHALL be 0 in I_ACC.
- m_req SHALL be 0 in IDLE.
REQ-009 In the cycle m_ack=1 in I_ACC, the block SHALL assert i_data_valid=1 with i_data_read=m_rdata (combinational), then return to IDLE.
REQ-010 In the cycle m_ack=1 in D_ACC, the block SHALL assert d_data_valid=1.
- d_data_read SHALL equal m_rdata for loads and 0 for stores.
- The block SHALL then return to IDLE.
REQ-011 Valid pulses SHALL last exactly one cycle; read data outputs SHALL be 0 when their valid is 0.
REQ-012 Minimum access SHALL be 2 cycles, grant to valid: one IDLE cycle, then one ACC cycle with m_ack.
REQ-013 m_ack in IDLE SHALL be ignored.
REQ-014 starve_cnt, 3 bits saturating at STARVE_MAX:
- SHALL increment on each D_ACC grant made while i_req=1;
- SHALL clear on each I_ACC grant;
- SHALL clear on any D_ACC grant made while i_req=0.
REQ-015 wait_cnt, 8 bits, SHALL clear on entry to I_ACC/D_ACC and increment each ACC cycle without m_ack.
REQ-016 When wait_cnt reaches TIMEOUT without m_ack, the block SHALL do the following in that cycle:
- pulse bus_error=1;
- pulse the active valid with data 0;
- deassert m_req from the next cycle;
- return to IDLE.
REQ-017 If m_ack and timeout coincide, m_ack SHALL win: normal completion, bus_error=0.

Reset
REQ-018 reset_n=0 SHALL asynchronously force:
- state IDLE, starve_cnt=0, wait_cnt=0;
- m_req=0, m_we=0, m_address=0, m_wdata=0;
- i_data_valid=0, d_data_valid=0, bus_error=0, read data outputs 0.
REQ-019 Reset mid-access SHALL abandon the access with no valid pulse.
- After deassertion the first grant SHALL occur on the first rising edge with a request pending.

Verification
REQ-020 Bench scenarios:
- Scenario 1, single fetch: i_req=1, i_address=0x100; memory acks on the 3rd ACC cycle with 0xCAFE0001 -> m_address=0x100, m_we=0 for 3 cycles; one-cycle i_data_valid with 0xCAFE0001.
- Scenario 2, simultaneous requests: i_req=d_req=1, d_write_enable=1, d_address=0x40, d_data_write=0x55; ack after 1 cycle -> D_ACC first with m_we=1, m_wdata=0x55, d_data_read=0; I_ACC granted next.
- Scenario 3, starvation: d_req held high with continuous back-to-back loads, i_req=1 -> exactly 4 D_ACC grants, then one I_ACC grant, then D_ACC resumes.
- Scenario 4, timeout: memory never acks -> bus_error and d_data_valid pulse together on the 255th ACC cycle with d_data_read=0; m_req low the next cycle; state IDLE.
- Scenario 5, reset mid-access: reset_n=0 during I_ACC -> m_req=0 immediately, no i_data_valid; after release, pending i_req re-granted and completes normally.
- Scenario 6, boundaries: m_ack in IDLE causes no valid; m_ack coinciding with timeout gives normal completion, bus_error=0.
